// File: rtl/scan_doubler_pkg.sv
// Shared definitions for the scan-doubler video path: output FSM states,
// colour width and default geometry parameters.
package scan_doubler_pkg;

    localparam int unsigned RGB_W        = 12;
    localparam int unsigned PERIOD_W     = 12;
    localparam int unsigned DEF_MAX_PIX  = 1024;
    localparam int unsigned DEF_HS_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2
    } sd_state_e;

endpackage

// File: rtl/scan_doubler_linebuf_dp.sv
// Simple dual-port line buffer: one write port, one registered read port.
// Contents are not reset; readers qualify the data with their own valid flag.
module linebuf_dp
    import scan_doubler_pkg::*;
#(
    parameter int unsigned AW = 11,
    parameter int unsigned DW = RGB_W + 1
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/scan_doubler.sv
// Scan doubler: stores each input line in one bank of a ping-pong buffer and
// replays it twice per input line period, with regenerated hsync and data enable.
module scan_doubler
    import scan_doubler_pkg::*;
#(
    parameter int unsigned MAX_PIX  = DEF_MAX_PIX,
    parameter int unsigned HS_WIDTH = DEF_HS_WIDTH
) (
    input  logic             C28M,
    input  logic             nRESET,
    input  logic             pix_en,
    input  logic [RGB_W-1:0] rgb_in,
    input  logic             zd_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic [RGB_W-1:0] rgb_out,
    output logic             zd_out,
    output logic             hs_out,
    output logic             vs_out,
    output logic             de_out,
    output logic             ovf
);

    localparam int unsigned AW  = $clog2(MAX_PIX);
    localparam int unsigned DW  = RGB_W + 1;
    localparam int unsigned HSW = $clog2(HS_WIDTH + 1);
    localparam logic [AW:0] PIX_LIMIT = (AW+1)'(MAX_PIX);
    localparam logic [AW:0] ADDR_ONE  = (AW+1)'(1);

    sd_state_e             state_q, state_d;
    logic                  hs_prev_q;
    logic                  seen_q;
    logic                  wr_bank_q;
    logic [AW:0]           wr_addr_q;
    logic [AW:0]           len_q [2];
    logic [PERIOD_W-1:0]   cyc_cnt_q;
    logic [PERIOD_W-1:0]   period_q;
    logic                  ovf_q;
    logic                  rd_bank_q;
    logic [AW:0]           rd_addr_q, rd_addr_d;
    logic [PERIOD_W-1:0]   out_cnt_q, out_cnt_d;
    logic                  rd_valid_q;
    logic                  first_q;
    logic [HSW-1:0]        hs_cnt_q;
    logic                  vs_q;

    logic                  line_start;
    logic                  wr_en;
    logic [AW:0]           wr_addr_inc;
    logic [AW:0]           cur_len;
    logic [PERIOD_W-1:0]   half;
    logic                  rd_go;
    logic                  pass_start;
    logic                  enter_p1;
    logic [DW-1:0]         ram_rdata;

    assign line_start  = hsync_in & ~hs_prev_q;
    assign wr_en       = pix_en && (wr_addr_q < PIX_LIMIT);
    assign wr_addr_inc = wr_en ? wr_addr_q + ADDR_ONE : wr_addr_q;
    assign cur_len     = len_q[rd_bank_q];
    assign half        = {1'b0, period_q[PERIOD_W-1:1]};
    // No read in a line-start cycle so an aborted pass never leaks into the new one.
    assign rd_go       = (state_q != IDLE) && !line_start && (rd_addr_q < cur_len);

    // Write side: a pixel coinciding with the hsync edge still lands in the old bank.
    always_ff @(posedge C28M or negedge nRESET) begin
        if (!nRESET) begin
            hs_prev_q <= 1'b1;
            seen_q    <= 1'b0;
            wr_bank_q <= 1'b0;
            wr_addr_q <= '0;
            len_q[0]  <= '0;
            len_q[1]  <= '0;
            cyc_cnt_q <= '0;
            period_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            hs_prev_q <= hsync_in;
            if (pix_en && !wr_en) begin
                ovf_q <= 1'b1;
            end
            if (line_start) begin
                len_q[wr_bank_q] <= wr_addr_inc;
                period_q         <= cyc_cnt_q;
                cyc_cnt_q        <= PERIOD_W'(1);
                wr_bank_q        <= ~wr_bank_q;
                wr_addr_q        <= '0;
                seen_q           <= 1'b1;
            end else begin
                wr_addr_q <= wr_addr_inc;
                if (cyc_cnt_q != '1) begin
                    cyc_cnt_q <= cyc_cnt_q + PERIOD_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        out_cnt_d  = out_cnt_q;
        pass_start = 1'b0;
        enter_p1   = 1'b0;
        if (rd_go) begin
            rd_addr_d = rd_addr_q + ADDR_ONE;
        end
        case (state_q)
            IDLE: begin
                if (line_start && seen_q) begin
                    enter_p1 = 1'b1;
                end
            end
            PASS1: begin
                out_cnt_d = out_cnt_q + PERIOD_W'(1);
                if (line_start) begin
                    enter_p1 = 1'b1;
                end else if (out_cnt_d >= half) begin
                    state_d    = PASS2;
                    rd_addr_d  = '0;
                    pass_start = 1'b1;
                end
            end
            PASS2: begin
                if (out_cnt_q != '1) begin
                    out_cnt_d = out_cnt_q + PERIOD_W'(1);
                end
                if (line_start) begin
                    enter_p1 = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_p1) begin
            state_d    = PASS1;
            rd_addr_d  = '0;
            out_cnt_d  = '0;
            pass_start = 1'b1;
        end
    end

    always_ff @(posedge C28M or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= IDLE;
            rd_bank_q  <= 1'b0;
            rd_addr_q  <= '0;
            out_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            first_q    <= 1'b0;
            hs_cnt_q   <= '0;
            vs_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            out_cnt_q  <= out_cnt_d;
            rd_valid_q <= rd_go;
            first_q    <= pass_start;
            if (line_start) begin
                rd_bank_q <= wr_bank_q;
            end
            if (enter_p1) begin
                vs_q <= vsync_in;
            end
            // Pulse starts with the first read data of a pass, one cycle after entry.
            if (first_q) begin
                hs_cnt_q <= HSW'(HS_WIDTH);
            end else if (hs_cnt_q != '0) begin
                hs_cnt_q <= hs_cnt_q - HSW'(1);
            end
        end
    end

    linebuf_dp #(
        .AW (AW + 1),
        .DW (DW)
    ) u_linebuf (
        .clk_i   (C28M),
        .we_i    (wr_en),
        .waddr_i ({wr_bank_q, wr_addr_q[AW-1:0]}),
        .wdata_i ({zd_in, rgb_in}),
        .re_i    (rd_go),
        .raddr_i ({rd_bank_q, rd_addr_q[AW-1:0]}),
        .rdata_o (ram_rdata)
    );

    assign rgb_out = rd_valid_q ? ram_rdata[RGB_W-1:0] : '0;
    assign zd_out  = rd_valid_q ? ram_rdata[RGB_W] : 1'b1;
    assign de_out  = rd_valid_q;
    assign hs_out  = (hs_cnt_q != '0);
    assign vs_out  = vs_q;
    assign ovf     = ovf_q;

endmodule
